// File: rtl/aes_sub_bytes_iter_if.sv
`default_nettype none
//============================================================================
// Module      : aes_sub_bytes_iter_if
// Description : Input/output handshake bundle for the iterative SubBytes engine.
// Revision    : 1.0 - initial release
//============================================================================
interface aes_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_sub_bytes_iter.sv
`default_nettype none
//============================================================================
// Module      : aes_sub_bytes_iter
// Description : Iterative forward AES SubBytes, BPC bytes substituted per cycle.
// Revision    : 1.0 - initial release
//============================================================================
module aes_sub_bytes_iter #(
    parameter int BPC = 4
) (
    input wire                  clk,
    input wire                  rst_n,
    aes_sub_bytes_iter_if.slave bus
);

    localparam int c_groups = 16 / BPC;
    localparam int c_cnt_w  = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_groups - 1);

    // Forward S-box, S(00) in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return c_sbox[2047 - 8 * int'(b) -: 8];
    endfunction

    generate
        if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bpc_check
            $error("aes_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    // Byte i of the state lives at element 15-i so that byte 0 is [127:120].
    logic [15:0][7:0]    r_work;
    logic [15:0][7:0]    w_work_next;
    logic [15:0][7:0]    w_work_sub;
    logic [127:0]        r_out;
    logic [127:0]        w_out_next;
    logic [3:0]          w_idx      [BPC];
    logic [7:0]          w_sub_byte [BPC];

    generate
        for (genvar k = 0; k < BPC; k++) begin : g_sbox
            assign w_idx[k]      = 4'(15 - k - BPC * int'(r_cnt));
            assign w_sub_byte[k] = f_sbox(r_work[w_idx[k]]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_work_next  = r_work;
        w_out_next   = r_out;
        w_work_sub   = r_work;
        for (int k = 0; k < BPC; k++) begin
            w_work_sub[w_idx[k]] = w_sub_byte[k];
        end

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_work_next  = bus.in_state;
                    w_cnt_next   = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_work_next = w_work_sub;
                w_cnt_next  = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_out_next   = w_work_sub;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_work  <= w_work_next;
            r_out   <= w_out_next;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_state = r_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_iter.sv
`default_nettype none
//============================================================================
// Module      : tb_aes_sub_bytes_iter
// Description : Scoreboard bench for aes_sub_bytes_iter at BPC = 4, 1 and 16.
// Revision    : 1.0 - initial release
//============================================================================
module tb_aes_sub_bytes_iter;

    logic         clk;
    logic         rst_n;
    logic         tb_in_valid  [3];
    logic [127:0] tb_in_state  [3];
    logic         tb_out_ready [3];
    logic         tb_in_ready  [3];
    logic         tb_out_valid [3];
    logic [127:0] tb_out_state [3];
    logic         tb_busy      [3];

    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   ref_tab [256];
    logic [127:0] sb [$];

    aes_sub_bytes_iter_if bus4 ();
    aes_sub_bytes_iter_if bus1 ();
    aes_sub_bytes_iter_if bus16 ();

    aes_sub_bytes_iter #(.BPC(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    aes_sub_bytes_iter #(.BPC(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    aes_sub_bytes_iter #(.BPC(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    assign bus4.in_valid  = tb_in_valid[0];
    assign bus4.in_state  = tb_in_state[0];
    assign bus4.out_ready = tb_out_ready[0];
    assign tb_in_ready[0]  = bus4.in_ready;
    assign tb_out_valid[0] = bus4.out_valid;
    assign tb_out_state[0] = bus4.out_state;
    assign tb_busy[0]      = bus4.busy;

    assign bus1.in_valid  = tb_in_valid[1];
    assign bus1.in_state  = tb_in_state[1];
    assign bus1.out_ready = tb_out_ready[1];
    assign tb_in_ready[1]  = bus1.in_ready;
    assign tb_out_valid[1] = bus1.out_valid;
    assign tb_out_state[1] = bus1.out_state;
    assign tb_busy[1]      = bus1.busy;

    assign bus16.in_valid  = tb_in_valid[2];
    assign bus16.in_state  = tb_in_state[2];
    assign bus16.out_ready = tb_out_ready[2];
    assign tb_in_ready[2]  = bus16.in_ready;
    assign tb_out_valid[2] = bus16.out_valid;
    assign tb_out_state[2] = bus16.out_state;
    assign tb_busy[2]      = bus16.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] golden(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = ref_tab[st[127 - 8 * i -: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, "/in_ready"},  128'(tb_in_ready[d]),  128'd1);
        chk({tag, "/out_valid"}, 128'(tb_out_valid[d]), 128'd0);
        chk({tag, "/busy"},      128'(tb_busy[d]),      128'd0);
        chk({tag, "/out_state"}, tb_out_state[d],       128'd0);
    endtask

    // One full transaction: accept, measure latency, score the result, release.
    task automatic xact(input int d, input logic [127:0] st, input int lat,
                        input string tag, output logic [127:0] obs);
        int           c;
        logic [127:0] exp;
        chk({tag, "/in_ready"}, 128'(tb_in_ready[d]), 128'd1);
        tb_in_valid[d] = 1'b1;
        tb_in_state[d] = st;
        sb.push_back(golden(st));
        tick();
        tb_in_valid[d] = 1'b0;
        tb_in_state[d] = ~st;
        c = 0;
        while (!tb_out_valid[d] && c < 40) begin
            tick();
            c++;
        end
        chk({tag, "/latency"}, 128'(c), 128'(lat));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        obs = tb_out_state[d];
        chk({tag, "/data"}, obs, exp);
        tb_out_ready[d] = 1'b1;
        tick();
        tb_out_ready[d] = 1'b0;
        chk({tag, "/release"}, 128'(tb_out_valid[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] obs;
        logic [127:0] bp_exp;
        logic [127:0] vecs [8];
        int           lats [3];
        int           n_in;
        int           n_out;
        int           cyc;
        int           last_t;
        bit           stray;

        lats[0] = 4;
        lats[1] = 16;
        lats[2] = 1;
        for (int i = 0; i < 256; i++) ref_tab[i] = sbox_calc(8'(i));
        for (int d = 0; d < 3; d++) begin
            tb_in_valid[d]  = 1'b0;
            tb_in_state[d]  = '0;
            tb_out_ready[d] = 1'b0;
        end

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) chk_reset_vals(d, $sformatf("reset%0d", d));

        for (int d = 0; d < 3; d++) begin
            xact(d, 128'h00112233445566778899aabbccddeeff, lats[d], $sformatf("known%0d", d), obs);
            chk($sformatf("known_const%0d", d), obs, 128'h638293c31bfc33f5c4eeacea4bc12816);
            xact(d, {16{8'h00}}, lats[d], $sformatf("zeros%0d", d), obs);
            chk($sformatf("zeros_const%0d", d), obs, {16{8'h63}});
            xact(d, {16{8'hff}}, lats[d], $sformatf("ones%0d", d), obs);
            chk($sformatf("ones_const%0d", d), obs, {16{8'h16}});
            xact(d, {8'h53, {15{8'h00}}}, lats[d], $sformatf("b53_%0d", d), obs);
            chk($sformatf("b53_const%0d", d), obs, {8'hed, {15{8'h63}}});
        end

        // Backpressure: hold the result while the producer keeps poking the input.
        tb_in_valid[0] = 1'b1;
        tb_in_state[0] = rand128();
        sb.push_back(golden(tb_in_state[0]));
        tick();
        tb_in_valid[0] = 1'b0;
        cyc = 0;
        while (!tb_out_valid[0] && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp/latency", 128'(cyc), 128'd4);
        bp_exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("bp/data", tb_out_state[0], bp_exp);
        for (int i = 0; i < 10; i++) begin
            tb_in_valid[0] = 1'($urandom_range(0, 1));
            tb_in_state[0] = rand128();
            tick();
            chk("bp/hold_valid", 128'(tb_out_valid[0]), 128'd1);
            chk("bp/hold_data",  tb_out_state[0],       bp_exp);
            chk("bp/in_ready",   128'(tb_in_ready[0]),  128'd0);
        end
        tb_in_valid[0]  = 1'b0;
        tb_out_ready[0] = 1'b1;
        tick();
        tb_out_ready[0] = 1'b0;
        chk("bp/idle_in_ready",  128'(tb_in_ready[0]),  128'd1);
        chk("bp/idle_out_valid", 128'(tb_out_valid[0]), 128'd0);
        chk("bp/idle_busy",      128'(tb_busy[0]),      128'd0);
        chk("bp/retained",       tb_out_state[0],       bp_exp);
        tick();
        chk("bp/no_second", 128'(tb_busy[0]), 128'd0);

        // Back-to-back streaming with both handshakes held open.
        for (int i = 0; i < 8; i++) vecs[i] = rand128();
        tb_out_ready[0] = 1'b1;
        n_in = 0;
        n_out = 0;
        last_t = 0;
        cyc = 0;
        while (n_out < 8 && cyc < 200) begin
            if (tb_out_valid[0]) begin
                obs = (sb.size() > 0) ? sb.pop_front() : 'x;
                chk($sformatf("b2b/data%0d", n_out), tb_out_state[0], obs);
                if (n_out > 0) chk($sformatf("b2b/gap%0d", n_out), 128'(cyc - last_t), 128'd6);
                last_t = cyc;
                n_out++;
            end
            if (n_in < 8) begin
                tb_in_valid[0] = 1'b1;
                tb_in_state[0] = vecs[n_in];
                if (tb_in_ready[0]) begin
                    sb.push_back(golden(vecs[n_in]));
                    n_in++;
                end
            end else begin
                tb_in_valid[0] = 1'b0;
            end
            tick();
            cyc++;
        end
        tb_in_valid[0]  = 1'b0;
        tb_out_ready[0] = 1'b0;
        chk("b2b/count", 128'(n_out), 128'd8);
        tick();

        // Reset two cycles into RUN: the aborted state must never surface.
        tb_in_valid[0] = 1'b1;
        tb_in_state[0] = rand128();
        tick();
        tb_in_valid[0] = 1'b0;
        tick();
        tick();
        chk("abort/busy_before", 128'(tb_busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0, "abort");
        tick();
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tb_out_valid[0]) stray = 1'b1;
        end
        chk("abort/no_out_valid", 128'(stray), 128'd0);
        xact(0, rand128(), 4, "after_abort", obs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
- Iterative forward SubBytes engine for the AES-256 encryption datapath. It is the encrypt-side counterpart of the decryption inverse S-box.
- Accepts a 128-bit state over a valid/ready handshake and substitutes every byte through the FIPS-197 forward S-box, BPC bytes per cycle.
- Returns the substituted state over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the sequential encryption round.

Parameters:
- BPC, 4, bytes substituted per cycle. Legal values 1, 2, 4, 8, 16; any other value is a compile-time error. Forward S-box instances = BPC.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  128  state to substitute; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  out_state holds a completed result
- out_ready  input  1  consumer accepts out_state
- out_state  output  128  substituted state, same byte order as in_state
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset, asynchronous on rst_n low, forces:
  - FSM = IDLE, byte counter = 0
  - working register = 0, out_state = 0
  - out_valid = 0, in_ready = 1, busy = 0
- Reset takes effect immediately, including mid-RUN or in DONE. Any partial result is discarded, and no out_valid is produced for the aborted state.
- FSM has three states:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_state into the working register, clear the counter, go to RUN.
  - RUN: in_ready = 0. Each cycle, bytes [cnt*BPC .. cnt*BPC+BPC-1] of the working register are replaced in place with S(byte), then cnt increments. On the cycle processing the final group (cnt = 16/BPC-1), the working register with that group substituted is registered into out_state, and the FSM goes to DONE.
  - DONE: out_valid = 1 and out_state is held stable. in_ready = 0, so no same-cycle accept of a new state. When out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises exactly 16/BPC cycles after the accepting clock edge. That is 4 cycles at BPC = 4, 16 at BPC = 1, 1 at BPC = 16.
- Throughput: one state per 16/BPC + 2 cycles when out_ready is held high. The extra 2 cycles are the DONE handshake and the IDLE accept.
- Counter width is clog2(16/BPC), minimum 1 bit. It wraps to 0 on entry to RUN only; it never free-runs in IDLE or DONE.
- The S-box is a pure combinational 256-entry forward table. Examples: S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16.
- Input handshake:
  - in_state is sampled only on the accepting edge.
  - Changes to in_state or in_valid during RUN or DONE are ignored.
  - in_valid asserted without in_ready creates no state change.
- Output handshake:
  - out_valid, once high, stays high until accepted.
  - out_state must not change while out_valid = 1.
  - out_ready while out_valid = 0 is ignored.
- After the DONE-to-IDLE transition, out_state retains the last result until the next completion; only out_valid qualifies it.

Test Plan:
- Reset/idle: assert rst_n = 0, release, with in_valid = 0 -> in_ready = 1, out_valid = 0, busy = 0, out_state = 0.
- Known vector (BPC = 4): in_state = 00112233445566778899AABBCCDDEEFF accepted -> after exactly 4 cycles out_valid = 1, out_state = 638293C31BFC33F5C4EEACEA4BC12816.
- Boundary bytes: in_state = all 00 -> all 63. all FF -> all 16. 53 in byte 0, 00 elsewhere -> ED6363...63 (ED followed by fifteen 63 bytes). Repeat with BPC = 1 (16-cycle latency) and BPC = 16 (1-cycle latency).
- Backpressure: hold out_ready = 0 for 10 cycles after completion while toggling in_valid and in_state -> out_valid and out_state stable, in_ready = 0, no second state accepted. Then raise out_ready for one cycle -> IDLE next cycle, in_ready = 1.
- Back-to-back: in_valid and out_ready held high with 8 distinct random states -> each result equals the golden S-box model, in order, one result per 6 cycles at BPC = 4.
- Reset mid-operation: drop rst_n two cycles into RUN, then release -> outputs at reset values immediately. No out_valid for the aborted state. The next accepted state completes correctly.
